// File: rtl/input_page_writer.sv
// input_page_writer: accepts a valid/ready word stream one event (BX) at a time,
// writes each event into its own page of a paged BRAM, publishes per-page entry
// counts, and hands closed pages to the consumer with a start pulse and the BX.
// The stream is held off while every page is handed off and not yet released.
module input_page_writer #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 16,
  parameter int PAGES     = 2,
  parameter int NENT_W    = 6,
  parameter int ADDR_W    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [RAM_WIDTH-1:0]      s_data,
  input  logic                      s_last,
  input  logic                      s_empty,
  output logic                      mem_wea,
  output logic [ADDR_W-1:0]         mem_writeaddr,
  output logic [RAM_WIDTH-1:0]      mem_din,
  output logic [PAGES*NENT_W-1:0]   nent_flat,
  output logic                      start_out,
  output logic [1:0]                bx_out,
  input  logic                      done_in,
  output logic                      overflow
);

  localparam int PAGE_W  = $clog2(PAGES);
  localparam int DEPTH_W = $clog2(RAM_DEPTH);
  localparam int IDX_W   = DEPTH_W + 1;   // idx must reach RAM_DEPTH itself
  localparam int BUSY_W  = PAGE_W + 1;    // busy must reach PAGES itself

  localparam logic [IDX_W-1:0]  DEPTH_C = IDX_W'(RAM_DEPTH);
  localparam logic [BUSY_W-1:0] PAGES_C = BUSY_W'(PAGES);

  logic [PAGE_W-1:0]    wrPage;
  logic [PAGE_W-1:0]    nextPage;
  logic [IDX_W-1:0]     idx;
  logic [BUSY_W-1:0]    busy;
  logic [BUSY_W-1:0]    busyNext;
  logic [1:0]           bxCnt;
  logic                 readyReg;
  logic                 weaReg;
  logic [ADDR_W-1:0]    addrReg;
  logic [RAM_WIDTH-1:0] dinReg;
  logic                 startReg;
  logic [1:0]           bxOutReg;
  logic                 overflowReg;

  logic accept;
  logic hasData;
  logic doWrite;
  logic doOverflow;
  logic doClose;
  logic doFree;

  // Beat decode; an empty closing beat carries no payload.
  assign accept     = s_valid & readyReg;
  assign hasData    = ~(s_last & s_empty);
  assign doWrite    = accept & hasData & (idx < DEPTH_C);
  assign doOverflow = accept & hasData & (idx == DEPTH_C);
  assign doClose    = accept & s_last;
  assign doFree     = done_in & (busy != '0);
  assign nextPage   = wrPage + PAGE_W'(1);   // pages are a power of 2, so this wraps

  // Handed-off page count: a close and a release in the same cycle cancel out.
  always_comb begin
    busyNext = busy;
    if (doClose && !doFree) begin
      busyNext = busy + BUSY_W'(1);
    end else if (!doClose && doFree) begin
      busyNext = busy - BUSY_W'(1);
    end
  end

  // Page/index/BX bookkeeping plus the registered ready flag.
  // Ready is computed from the next busy value so it is a pure register output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPage   <= '0;
      idx      <= '0;
      busy     <= '0;
      bxCnt    <= '0;
      readyReg <= 1'b0;
    end else begin
      busy     <= busyNext;
      readyReg <= (busyNext < PAGES_C);
      if (doClose) begin
        wrPage <= nextPage;
        idx    <= '0;
        bxCnt  <= bxCnt + 2'd1;
      end else if (doWrite) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Registered BRAM write port; address and data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weaReg  <= 1'b0;
      addrReg <= '0;
      dinReg  <= '0;
    end else begin
      weaReg <= doWrite;
      if (doWrite) begin
        addrReg <= {wrPage, idx[DEPTH_W-1:0]};
        dinReg  <= s_data;
      end
    end
  end

  // Close handshake to the consumer and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      startReg    <= 1'b0;
      bxOutReg    <= '0;
      overflowReg <= 1'b0;
    end else begin
      startReg <= doClose;
      if (doClose) begin
        bxOutReg <= bxCnt;
      end
      if (doOverflow) begin
        overflowReg <= 1'b1;
      end
    end
  end

  // Per-page entry counters: cleared when the page becomes the fill page,
  // incremented on each write into it. Freed pages keep their count until reuse.
  for (genvar gi = 0; gi < PAGES; gi++) begin : gPage
    logic [NENT_W-1:0] nentReg;

    // Entry count of page gi.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        nentReg <= '0;
      end else if (doClose && (nextPage == PAGE_W'(gi))) begin
        nentReg <= '0;
      end else if (doWrite && (wrPage == PAGE_W'(gi))) begin
        nentReg <= nentReg + NENT_W'(1);
      end
    end

    assign nent_flat[gi*NENT_W +: NENT_W] = nentReg;
  end

  assign s_ready       = readyReg;
  assign mem_wea       = weaReg;
  assign mem_writeaddr = addrReg;
  assign mem_din       = dinReg;
  assign start_out     = startReg;
  assign bx_out        = bxOutReg;
  assign overflow      = overflowReg;

endmodule

// File: tb/tb_input_page_writer.sv
// Directed bench for input_page_writer: expected writes and start pulses are
// queued as beats are driven and consumed as the DUT produces them.
module tb_input_page_writer;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 16;
  localparam int PAGES     = 2;
  localparam int NENT_W    = 6;
  localparam int ADDR_W    = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [RAM_WIDTH-1:0]    s_data = '0;
  logic                    s_last = 1'b0;
  logic                    s_empty = 1'b0;
  logic                    mem_wea;
  logic [ADDR_W-1:0]       mem_writeaddr;
  logic [RAM_WIDTH-1:0]    mem_din;
  logic [PAGES*NENT_W-1:0] nent_flat;
  logic                    start_out;
  logic [1:0]              bx_out;
  logic                    done_in = 1'b0;
  logic                    overflow;

  input_page_writer #(
    .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .PAGES(PAGES),
    .NENT_W(NENT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_empty(s_empty),
    .mem_wea(mem_wea), .mem_writeaddr(mem_writeaddr), .mem_din(mem_din),
    .nent_flat(nent_flat), .start_out(start_out), .bx_out(bx_out),
    .done_in(done_in), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [RAM_WIDTH-1:0] data; } wr_t;
  typedef struct { logic [1:0] bx; logic wr; } st_t;
  wr_t wrQ[$];
  st_t stQ[$];
  wr_t wPop;
  st_t sPop;

  int checkCnt = 0;
  int passCnt  = 0;

  // Reference state of the writer.
  int          mIdx = 0, mPage = 0, mBusy = 0, mBx = 0, mLastBx = 0;
  logic [5:0]  mNent[2] = '{6'd0, 6'd0};
  bit          mOverflow = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor: every write / start pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mem_wea === 1'b1) begin
      check("write expected", 64'(wrQ.size() != 0), 64'd1);
      if (wrQ.size() != 0) begin
        wPop = wrQ.pop_front();
        check("write addr", 64'(mem_writeaddr), 64'(wPop.addr));
        check("write data", 64'(mem_din), 64'(wPop.data));
        $display("write addr=%0d data=%08h", mem_writeaddr, mem_din);
      end
    end
    if (start_out === 1'b1) begin
      check("start expected", 64'(stQ.size() != 0), 64'd1);
      if (stQ.size() != 0) begin
        sPop = stQ.pop_front();
        check("start bx_out", 64'(bx_out), 64'(sPop.bx));
        check("start aligned with write", 64'(mem_wea), 64'(sPop.wr));
        $display("start bx=%0d with_write=%0d", bx_out, mem_wea);
      end
    end
  end

  // One beat; optional done_in in the same cycle.
  task automatic beat(input logic [31:0] d, input bit last, input bit empty, input bit withDone);
    bit wrote;
    bit freeOk;
    check("s_ready before beat", 64'(s_ready), 64'(mBusy < PAGES));
    s_valid = 1'b1; s_data = d; s_last = last; s_empty = empty; done_in = withDone;
    wrote  = 1'b0;
    freeOk = withDone && (mBusy > 0);
    if (!(last && empty)) begin
      if (mIdx < RAM_DEPTH) begin
        wrQ.push_back('{addr: ADDR_W'(mPage * RAM_DEPTH + mIdx), data: d});
        mIdx++;
        mNent[mPage]++;
        wrote = 1'b1;
      end else begin
        mOverflow = 1'b1;
      end
    end
    if (last) begin
      stQ.push_back('{bx: 2'(mBx), wr: wrote});
      mLastBx = mBx;
      mBx = (mBx + 1) % 4;
      mPage = (mPage + 1) % PAGES;
      mIdx = 0;
      mNent[mPage] = 6'd0;
      mBusy++;
    end
    if (freeOk) mBusy--;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; done_in = 1'b0;
  endtask

  task automatic pulseDone();
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    if (mBusy > 0) mBusy--;
  endtask

  task automatic event_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(base + 32'(i), i == n - 1, 1'b0, 1'b0);
  endtask

  // Compare published state once the monitor has drained this cycle's outputs.
  task automatic checkState(input string tag);
    @(negedge clk); #1;
    check({tag, " nent_flat"}, 64'(nent_flat), 64'({mNent[1], mNent[0]}));
    check({tag, " s_ready"}, 64'(s_ready), 64'(mBusy < PAGES));
    check({tag, " overflow"}, 64'(overflow), 64'(mOverflow));
    check({tag, " bx_out"}, 64'(bx_out), 64'(mLastBx));
    check({tag, " writes drained"}, 64'(wrQ.size()), 64'd0);
    check({tag, " starts drained"}, 64'(stQ.size()), 64'd0);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk); #1;
    reset = 1'b0;
    check("reset pending writes", 64'(wrQ.size()), 64'd0);
    wrQ.delete(); stQ.delete();
    mIdx = 0; mPage = 0; mBusy = 0; mBx = 0; mLastBx = 0;
    mNent[0] = 6'd0; mNent[1] = 6'd0; mOverflow = 1'b0;
    #1;
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset outputs", 64'({mem_wea, mem_writeaddr, start_out, bx_out, overflow, nent_flat}), 64'd0);
    check("reset mem_din", 64'(mem_din), 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    check("s_ready low at release", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("s_ready after release", 64'(s_ready), 64'd1);
  endtask

  initial begin
    #2;
    // Reset, release, idle.
    doReset(3);
    repeat (4) @(posedge clk);
    checkState("idle");

    // 3-beat event A,B,C -> addr 0..2, bx 0.
    beat(32'hA, 1'b0, 1'b0, 1'b0);
    beat(32'hB, 1'b0, 1'b0, 1'b0);
    beat(32'hC, 1'b1, 1'b0, 1'b0);
    checkState("three beats");
    pulseDone();

    // Two back-to-back 2-beat events fill both pages; ready drops.
    event_n(2, 32'h1000_0000);
    event_n(2, 32'h2000_0000);
    checkState("pages full");
    pulseDone();
    checkState("after done");
    event_n(2, 32'h3000_0000);
    checkState("third event");
    pulseDone();
    pulseDone();

    // 20-beat event: only 16 written, overflow sticks.
    event_n(20, 32'h4000_0000);
    checkState("overflow event");
    pulseDone();

    // Empty events: no writes, count cleared, BX wraps.
    beat(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    checkState("empty event");
    pulseDone();
    for (int k = 0; k < 4; k++) begin
      beat(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      checkState("empty wrap");
      pulseDone();
    end

    // done_in together with a close at busy=1 keeps busy at 1.
    event_n(1, 32'h5000_0000);
    beat(32'h6000_0000, 1'b1, 1'b0, 1'b1);
    checkState("done with close");
    pulseDone();
    // done_in at busy=0 is ignored: two closes must still fill the pages.
    pulseDone();
    checkState("ignored done");
    event_n(1, 32'h7000_0000);
    event_n(1, 32'h7100_0000);
    checkState("full after ignored done");
    pulseDone();
    pulseDone();

    // Reset in the middle of an event discards it.
    beat(32'h8000_0000, 1'b0, 1'b0, 1'b0);
    beat(32'h8000_0001, 1'b0, 1'b0, 1'b0);
    doReset(2);
    checkState("after mid-event reset");
    event_n(2, 32'h9000_0000);
    checkState("first event after reset");

    repeat (3) @(posedge clk);
    checkState("final");
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/input_page_writer.md
# input_page_writer

Producer-side writer for the paged input memories that the processing chain reads through its `readaddr` / `nent` / `dout` ports. It accepts a valid/ready word stream, one event (BX) at a time. Each event's words go into one page of a `PAGES`-deep paged BRAM, and the block publishes the per-page entry counts. When a page closes, it pulses a start to the first process with that event's BX, and it holds off the input stream until the consumer releases the page via its done.

## Interface
Parameters:
- `RAM_WIDTH`, 32, data word width.
- `RAM_DEPTH`, 16, entries per page (power of 2).
- `PAGES`, 2, number of pages (power of 2, ≥2).
- `NENT_W`, 6, entry-count width; must hold `RAM_DEPTH`.
- `ADDR_W`, 5, write address width, = log2(`RAM_DEPTH`*`PAGES`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_data`  in  RAM_WIDTH  beat payload.
- `s_last`  in  1  beat closes the current event.
- `s_empty`  in  1  with `s_last`: beat carries no data (`s_data` ignored).
- `mem_wea`  out  1  BRAM write enable.
- `mem_writeaddr`  out  ADDR_W  = page*`RAM_DEPTH` + index.
- `mem_din`  out  RAM_WIDTH  BRAM write data.
- `nent_flat`  out  PAGES*NENT_W  entry count per page; page p in bits [p*NENT_W +: NENT_W].
- `start_out`  out  1  one-cycle pulse: page closed, event ready for the consumer.
- `bx_out`  out  2  BX of the most recently closed event.
- `done_in`  in  1  one-cycle pulse from the consumer: oldest handed-off page is freed.
- `overflow`  out  1  sticky: an event exceeded `RAM_DEPTH`.

## Operation
Registered state:
- `wr_page`: page being filled.
- `idx`: next entry in the page, range 0..`RAM_DEPTH`.
- `busy`: pages handed off and not yet freed, range 0..`PAGES`.
- `bx_cnt`: 2 bits.

Handshake and page ownership:
- `s_ready` = (`busy` < `PAGES`), driven from registered state only. `s_valid` has no combinational effect on it.
- Per-page state: FREE → FILLING (when it becomes `wr_page`) → HANDED (on close) → FREE (on `done_in`).
- Pages are handed off and freed in order, modulo `PAGES`.

Accepted beat (`s_valid` & `s_ready`):
- If not empty and `idx` < `RAM_DEPTH`: write at `wr_page`*`RAM_DEPTH` + `idx`, then `idx`++ and `nent[wr_page]`++.
- If not empty and `idx` == `RAM_DEPTH`: no write, `overflow` ← 1, `nent` stays at `RAM_DEPTH`.
- If `s_last`:
  - `start_out` pulses and `bx_out` ← `bx_cnt`.
  - `bx_cnt`++ (3 wraps to 0).
  - `wr_page`++ (wraps), `idx` ← 0, `busy`++.
  - `nent` of the new `wr_page` is cleared to 0.

`done_in`:
- If `busy` > 0: `busy`--.
- If `busy` == 0: ignored, no state change.
- `done_in` and a closing beat in the same cycle: net `busy` unchanged.
- Freed page contents are not cleared; its `nent` is cleared only when it next becomes `wr_page`.

Reset (asserted at any time, including mid-event):
- All registers and outputs go to 0, `wr_page` = 0.
- A partial event is discarded, with no `start_out`.

## Timing
- Beat accepted at edge N: `mem_wea` / `mem_writeaddr` / `mem_din` are valid in cycle N+1 only (registered). `nent` updates in the same cycle as the write.
- A closing beat accepted at N: `start_out` = 1 during N+1, coincident with that beat's write (if any). `bx_out` and the closed page's `nent` are stable from N+1 until the next close.
- `s_ready` deasserts in the cycle after the close that makes `busy` == `PAGES`. `done_in` at N reasserts `s_ready` in N+1.
- Full throughput: one beat per cycle while `s_ready`. Back-to-back events allowed (last of one event, first of the next on consecutive cycles).
- Reset values: `s_ready` = 0 while `reset` = 0, and 1 on the first cycle after release. `mem_wea` = 0, `mem_writeaddr` = 0, `mem_din` = 0, `nent_flat` = 0, `start_out` = 0, `bx_out` = 0, `overflow` = 0.

## Test plan
- Reset then release, idle: every output 0. `s_ready` = 1 one cycle after release. No `mem_wea` without beats.
- Event of 3 beats (A, B, C, last on C): writes addr 0, 1, 2 with A, B, C. `nent` page0 = 3. `start_out` pulses once, aligned with the addr-2 write. `bx_out` = 0.
- Two 2-beat events, no `done_in`:
  - Second event writes addr 16, 17. `bx_out` = 1, page1 `nent` = 2, then `s_ready` = 0.
  - `done_in` pulse → `s_ready` = 1 next cycle.
  - Third event writes addr 0, with page0 `nent` restarting at 1. `bx_out` = 2.
- 20-beat event: writes addr 0..15 only. `nent` = 16, `overflow` = 1 and stays set through later events until reset.
- Empty event (`s_last` & `s_empty`): no `mem_wea`, page `nent` = 0, `start_out` pulse. Four more empty events with `done_in` after each: `bx_out` wraps 3 → 0.
- Corner cases:
  - `busy` = 1: `done_in` coinciding with a closing beat leaves `busy` = 1, `s_ready` = 1.
  - `done_in` at `busy` = 0: ignored.
  - `reset` pulled low after 2 beats of an event: no `start_out`, all `nent` = 0, next event starts at addr 0 with `bx_out` = 0.
